segment_scan_decoder: RTL and testbench
=======================================

# segment_scan_decoder

Passive monitor on the seven-segment display interface: samples the multiplexed score lines and the lives lines, decodes segment patterns back into digits, and rebuilds the binary score and lives values. It sits beside the display driver, on the same anode/cathode nets. It is used for on-chip self-check and as a bench scoreboard. It filters mux glitches with a per-position stability counter and flags illegal patterns.

## Interface
- STABLE_CYCLES, 4: number of consecutive identical samples a digit position needs before its value is accepted; must be ≥1.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- sample_en  in  1  sample strobe, one clk wide, at the display refresh rate; all line inputs are ignored when low.
- an_score  in  1  score digit select: 0 = ones, 1 = tens.
- seg_score  in  7  score cathodes, active-high, bit order {g,f,e,d,c,b,a}.
- an_lives  in  4  lives anodes, active-low.
- seg_lives  in  7  lives cathodes, active-low, same bit order.
- err_clr  in  1  clears err.
- score  out  7  reconstructed score, 0..99.
- lives  out  2  reconstructed lives, 0..3.
- update  out  1  one-cycle pulse when score or lives changes value.
- err  out  1  sticky illegal-pattern flag.

## Operation
- Active-high decode table, digits 0–9: 0111111, 0000110, 1011011, 1001111, 1100110, 1101101, 1111101, 0000111, 1111111, 1101111.
- The active-low table is the bitwise inverse of the active-high table.
- Score path, on each sample_en, for the position selected by an_score:
  - Pattern is a legal digit equal to that position's candidate: the position's counter increments, saturating at STABLE_CYCLES.
  - Legal digit that differs from the candidate: the candidate is loaded with the new digit and the counter is set to 1.
  - Blank pattern (0000000): counter cleared, no error.
  - Any other pattern: counter cleared and err set.
- Samples taken for the other position do not break a position's streak.
- Commit:
  - When a position's counter reaches STABLE_CYCLES, the candidate is written to that position's digit register and the position's seen flag is set.
  - Committing the same value again is harmless.
- Score publish:
  - Score is published only once both seen flags are set.
  - Published value = tens×10 + ones, computed at 7 bits (maximum 99, no overflow).
- Lives path:
  - Sampled only when sample_en is high and an_lives == 1110; any other anode value is ignored.
  - Blank (1111111): counter cleared, no error.
  - Legal digit 0–3: same candidate/counter/commit rules as the score path.
  - Legal digit 4–9, or an illegal pattern: err set, counter cleared, lives unchanged.
  - Lives publishes on its first commit.
- update:
  - Pulses when the published score or lives register takes a new value.
  - A simultaneous score and lives change gives a single pulse.
  - Republishing an unchanged value gives no pulse.
- err:
  - Set on any error event.
  - err_clr clears it on the next edge.
  - err_clr in the same cycle as a new error: err stays 1 (set wins).

## Timing
- Reset (rst_n low, takes effect immediately, asynchronous):
  - Outputs: score=0, lives=0, update=0, err=0.
  - Internal state: all candidates, counters and seen flags cleared.
- Reset asserted mid-stream discards all partial streaks. After release, a full STABLE_CYCLES run per position is required again.
- Sample at cycle N that completes a streak: the digit register is updated at the edge ending N.
- score/lives outputs and update are registered at the edge ending N+1, giving 2 clk of latency from the final qualifying sample.
- Minimum time to first score: STABLE_CYCLES samples per position, 2×STABLE_CYCLES strobes when interleaved.
- Counter width is clog2(STABLE_CYCLES+1); counters saturate and never wrap.
- err_clr takes effect on the edge after it is asserted; err_clr with sample_en low simply clears.

## Configuration
- SEG_SCAN_LIVES_EN defined: the lives path is built as described.
- SEG_SCAN_LIVES_EN undefined:
  - No lives logic is built; an_lives and seg_lives are ignored.
  - lives is held at 0.
  - Lives never causes update or err.
  - The score path is unchanged.

## Test plan
- Reset: pulse rst_n low asynchronously mid-stream after score=25 -> score=0, lives=0, err=0 immediately. A fresh 4+4 sample run is then needed before score returns.
- Normal score (STABLE_CYCLES=4): interleave an_score 0/1 with ones=1101101 (5) and tens=1011011 (2), 4 samples each -> score=25 two cycles after the last qualifying sample, update high exactly one cycle.
- Glitch filter: with score=25, drive ones=0000110 (1) for 3 samples, then 1101101 again -> score stays 25, no update.
- Errors:
  - seg_score=1010101 -> err=1 and stays 1.
  - err_clr together with another illegal sample -> err=1.
  - err_clr alone -> err=0.
- Lives:
  - an_lives=1110, seg_lives=0100100 (2) for 4 samples -> lives=2, update pulse.
  - seg_lives=0011001 (4) -> err=1, lives stays 2.
  - an_lives=1111 with garbage on seg_lives -> no effect.
- Macro off: repeat the lives scenario -> lives=0, no update, err stays 0.

Source files
------------

// File: rtl/segment_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : segment_scan_decoder
// Description : Passive monitor on a multiplexed seven-segment display bus.
//               Decodes the score digits (active-high cathodes, an_score
//               selects ones/tens) and the lives digit (active-low cathodes,
//               active-low anodes, position 1110 only) back into binary,
//               filtering mux glitches with a per-position stability counter
//               and flagging illegal patterns on a sticky error bit.
// Configuration macro:
//               SEG_SCAN_LIVES_EN - when defined the lives path is built;
//               when undefined lives_o is tied to 0 and the lives lines are
//               ignored.
// Ports       :
//   clk          - system clock
//   rst_n        - asynchronous active-low reset
//   sample_en_i  - one-cycle sample strobe; all line inputs ignored when low
//   an_score_i   - score digit select (0 = ones, 1 = tens)
//   seg_score_i  - score cathodes, active-high, {g,f,e,d,c,b,a}
//   an_lives_i   - lives anodes, active-low
//   seg_lives_i  - lives cathodes, active-low, {g,f,e,d,c,b,a}
//   err_clr_i    - clears the sticky error flag
//   score_o      - reconstructed score, 0..99
//   lives_o      - reconstructed lives, 0..3
//   update_o     - one-cycle pulse when score or lives changes
//   err_o        - sticky illegal-pattern flag
// Revision    : 1.0 - initial release
// ============================================================================
module segment_scan_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_en_i,
  input  logic       an_score_i,
  input  logic [6:0] seg_score_i,
  input  logic [3:0] an_lives_i,
  input  logic [6:0] seg_lives_i,
  input  logic       err_clr_i,
  output logic [6:0] score_o,
  output logic [1:0] lives_o,
  output logic       update_o,
  output logic       err_o
);

  localparam int            CW       = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] C_STABLE = CW'(STABLE_CYCLES);

  // Returns {legal, digit} for an active-high segment pattern.
  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    logic [4:0] r;
    r = 5'b0_0000;
    case (seg)
      7'b0111111: r = 5'b1_0000;
      7'b0000110: r = 5'b1_0001;
      7'b1011011: r = 5'b1_0010;
      7'b1001111: r = 5'b1_0011;
      7'b1100110: r = 5'b1_0100;
      7'b1101101: r = 5'b1_0101;
      7'b1111101: r = 5'b1_0110;
      7'b0000111: r = 5'b1_0111;
      7'b1111111: r = 5'b1_1000;
      7'b1101111: r = 5'b1_1001;
      default:    r = 5'b0_0000;
    endcase
    return r;
  endfunction

  // Candidate/counter update shared by every digit position. Returns
  // {cand_next, cnt_next}. Any non-legal sample (blank or illegal) clears
  // the streak; the caller decides whether it is also an error.
  function automatic logic [CW+3:0] chan_next(
    input logic          hit,
    input logic          legal,
    input logic [3:0]    digit,
    input logic [3:0]    cand,
    input logic [CW-1:0] cnt
  );
    logic [3:0]    c;
    logic [CW-1:0] n;
    c = cand;
    n = cnt;
    if (hit) begin
      if (legal) begin
        if (digit == cand) begin
          if (cnt != C_STABLE) n = cnt + CW'(1);
        end else begin
          c = digit;
          n = CW'(1);
        end
      end else begin
        n = '0;
      end
    end
    return {c, n};
  endfunction

  // --------------------------------------------------------------------------
  // Score path
  // --------------------------------------------------------------------------
  logic [4:0] sc_dec;
  logic       sc_legal;
  logic       sc_blank;
  logic       sc_err;
  logic [7:0] sc_digits;   // {tens, ones}
  logic [1:0] sc_seen;

  assign sc_dec   = decode_seg(seg_score_i);
  assign sc_legal = sc_dec[4];
  assign sc_blank = (seg_score_i == 7'b0000000);
  assign sc_err   = sample_en_i && !sc_legal && !sc_blank;

  for (genvar gi = 0; gi < 2; gi++) begin : g_score_pos
    logic          hit;
    logic          commit;
    logic [3:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    digit_q;
    logic          seen_q;

    // Samples for the other position leave this streak untouched.
    assign hit            = sample_en_i && (an_score_i == 1'(gi));
    assign {cand_d, cnt_d} = chan_next(hit, sc_legal, sc_dec[3:0], cand_q, cnt_q);
    // Saturated streaks keep recommitting the same value, which is harmless.
    assign commit         = hit && sc_legal && (cnt_d == C_STABLE);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cand_q  <= '0;
        cnt_q   <= '0;
        digit_q <= '0;
        seen_q  <= 1'b0;
      end else begin
        cand_q <= cand_d;
        cnt_q  <= cnt_d;
        if (commit) begin
          digit_q <= cand_d;
          seen_q  <= 1'b1;
        end
      end
    end

    assign sc_digits[gi*4 +: 4] = digit_q;
    assign sc_seen[gi]          = seen_q;
  end

  logic [6:0] score_q, score_d;

  // Publish only once both positions have committed at least once.
  assign score_d = (sc_seen == 2'b11)
                 ? ({3'b000, sc_digits[7:4]} * 7'd10 + {3'b000, sc_digits[3:0]})
                 : score_q;

  // --------------------------------------------------------------------------
  // Lives path
  // --------------------------------------------------------------------------
  logic [1:0] lives_q, lives_d;
  logic       lv_err;

`ifdef SEG_SCAN_LIVES_EN
  logic [4:0]    lv_dec;
  logic          lv_hit;
  logic          lv_legal;
  logic          lv_blank;
  logic          lv_commit;
  logic [3:0]    lv_cand_q, lv_cand_d;
  logic [CW-1:0] lv_cnt_q, lv_cnt_d;
  logic [1:0]    lv_digit_q;
  logic          lv_seen_q;

  // Active-low table is the inverse of the active-high one.
  assign lv_dec   = decode_seg(~seg_lives_i);
  assign lv_hit   = sample_en_i && (an_lives_i == 4'b1110);
  assign lv_legal = lv_dec[4] && (lv_dec[3:2] == 2'b00);
  assign lv_blank = (seg_lives_i == 7'b1111111);
  // Digits 4..9 are legal display patterns but impossible lives values.
  assign lv_err   = lv_hit && !lv_blank && !lv_legal;

  assign {lv_cand_d, lv_cnt_d} = chan_next(lv_hit, lv_legal, lv_dec[3:0], lv_cand_q, lv_cnt_q);
  assign lv_commit = lv_hit && lv_legal && (lv_cnt_d == C_STABLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lv_cand_q  <= '0;
      lv_cnt_q   <= '0;
      lv_digit_q <= '0;
      lv_seen_q  <= 1'b0;
    end else begin
      lv_cand_q <= lv_cand_d;
      lv_cnt_q  <= lv_cnt_d;
      if (lv_commit) begin
        lv_digit_q <= lv_cand_d[1:0];
        lv_seen_q  <= 1'b1;
      end
    end
  end

  assign lives_d = lv_seen_q ? lv_digit_q : lives_q;
`else
  logic lives_unused;
  assign lives_unused = ^{an_lives_i, seg_lives_i};
  assign lv_err       = 1'b0;
  assign lives_d      = 2'b00;
`endif

  // --------------------------------------------------------------------------
  // Output registers
  // --------------------------------------------------------------------------
  logic update_q, update_d;
  logic err_q, err_d;

  assign update_d = (score_d != score_q) || (lives_d != lives_q);
  // A new error wins over a simultaneous clear.
  assign err_d    = (sc_err || lv_err) ? 1'b1 : (err_clr_i ? 1'b0 : err_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_q  <= '0;
      lives_q  <= '0;
      update_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      score_q  <= score_d;
      lives_q  <= lives_d;
      update_q <= update_d;
      err_q    <= err_d;
    end
  end

  assign score_o  = score_q;
  assign lives_o  = lives_q;
  assign update_o = update_q;
  assign err_o    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_segment_scan_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_segment_scan_decoder
// Description : Directed scoreboard bench for segment_scan_decoder. Expected
//               {score, lives} pairs are queued as stimulus is issued; a
//               monitor pops one entry per update pulse. Lives expectations
//               follow SEG_SCAN_LIVES_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_segment_scan_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sample_en;
  logic       an_score;
  logic [6:0] seg_score;
  logic [3:0] an_lives;
  logic [6:0] seg_lives;
  logic       err_clr;
  logic [6:0] score;
  logic [1:0] lives;
  logic       update;
  logic       err;

  always #5 clk = ~clk;

  segment_scan_decoder #(.STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_en_i (sample_en),
    .an_score_i  (an_score),
    .seg_score_i (seg_score),
    .an_lives_i  (an_lives),
    .seg_lives_i (seg_lives),
    .err_clr_i   (err_clr),
    .score_o     (score),
    .lives_o     (lives),
    .update_o    (update),
    .err_o       (err)
  );

`ifdef SEG_SCAN_LIVES_EN
  localparam bit LV = 1'b1;
`else
  localparam bit LV = 1'b0;
`endif

  // Active-high score patterns
  localparam logic [6:0] S1 = 7'b0000110;
  localparam logic [6:0] S2 = 7'b1011011;
  localparam logic [6:0] S3 = 7'b1001111;
  localparam logic [6:0] S5 = 7'b1101101;
  localparam logic [6:0] S9 = 7'b1101111;
  localparam logic [6:0] SBAD = 7'b1010101;
  // Active-low lives patterns
  localparam logic [6:0] L1 = 7'b1111001;
  localparam logic [6:0] L2 = 7'b0100100;
  localparam logic [6:0] L4 = 7'b0011001;

  typedef struct packed {
    logic [6:0] s;
    logic [1:0] l;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic push(input int s, input int l);
    exp_t e;
    e.s = 7'(s);
    e.l = 2'(l);
    q.push_back(e);
  endtask

  // Monitor: every update pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && update === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_update: score=%0d lives=%0d, no pulse expected at %0t",
                 score, lives, $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("upd_score", int'(score), int'(e.s));
        chk("upd_lives", int'(lives), int'(e.l));
      end
    end
  end

  task automatic idle_inputs();
    sample_en = 1'b0;
    an_score  = 1'b0;
    seg_score = 7'b0000000;
    an_lives  = 4'b1111;
    seg_lives = 7'b1111111;
    err_clr   = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One strobe cycle followed by return at the next falling edge.
  task automatic step(input logic en, input logic as, input logic [6:0] ss,
                      input logic [3:0] al, input logic [6:0] sl, input logic clr);
    @(negedge clk);
    sample_en = en;
    an_score  = as;
    seg_score = ss;
    an_lives  = al;
    seg_lives = sl;
    err_clr   = clr;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic sc(input logic pos, input logic [6:0] seg);
    step(1'b1, pos, seg, 4'b1111, 7'b1111111, 1'b0);
  endtask

  task automatic lv(input logic [3:0] al, input logic [6:0] sl);
    step(1'b1, 1'b0, 7'b0000000, al, sl, 1'b0);
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("reset_score",  int'(score),  0);
    chk("reset_lives",  int'(lives),  0);
    chk("reset_update", int'(update), 0);
    chk("reset_err",    int'(err),    0);
    #20 rst_n = 1'b1;

    // Interleaved ones=5 / tens=2, four samples each.
    push(25, 0);
    for (int k = 0; k < 3; k++) begin
      sc(1'b0, S5);
      sc(1'b1, S2);
    end
    wait_cyc(3);
    chk("score_before_streak", int'(score), 0);
    sc(1'b0, S5);
    sc(1'b1, S2);
    wait_cyc(3);
    chk("score_25", int'(score), 25);

    // Glitch on ones shorter than the streak length.
    for (int k = 0; k < 3; k++) sc(1'b0, S1);
    sc(1'b0, S5);
    wait_cyc(3);
    chk("glitch_score", int'(score), 25);
    chk("glitch_err",   int'(err),   0);

    // Error handling
    sc(1'b0, SBAD);
    chk("err_set", int'(err), 1);
    wait_cyc(4);
    chk("err_sticky", int'(err), 1);
    step(1'b1, 1'b0, SBAD, 4'b1111, 7'b1111111, 1'b1);
    chk("err_set_wins", int'(err), 1);
    step(1'b0, 1'b0, 7'b0000000, 4'b1111, 7'b1111111, 1'b1);
    chk("err_clr", int'(err), 0);

    // Lives = 2
    if (LV) push(25, 2);
    for (int k = 0; k < 4; k++) lv(4'b1110, L2);
    wait_cyc(3);
    chk("lives_2",     int'(lives), LV ? 2 : 0);
    chk("lives_noerr", int'(err),   0);
    lv(4'b1110, L4);
    chk("lives_4_err", int'(err),   LV ? 1 : 0);
    wait_cyc(3);
    chk("lives_4_keep", int'(lives), LV ? 2 : 0);
    step(1'b0, 1'b0, 7'b0000000, 4'b1111, 7'b1111111, 1'b1);
    chk("err_clr2", int'(err), 0);
    for (int k = 0; k < 4; k++) lv(4'b1111, 7'b0011010);
    wait_cyc(3);
    chk("lives_anode_off", int'(lives), LV ? 2 : 0);
    chk("err_anode_off",   int'(err),   0);

    // Score and lives completing on the same strobe: one pulse.
    push(23, LV ? 1 : 0);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, S3, 4'b1110, L1, 1'b0);
    wait_cyc(3);
    chk("score_23", int'(score), 23);
    chk("lives_1",  int'(lives), LV ? 1 : 0);

    // Maximum score 99: ones commits first (29), then tens (99).
    push(29, LV ? 1 : 0);
    push(99, LV ? 1 : 0);
    for (int k = 0; k < 4; k++) sc(1'b0, S9);
    wait_cyc(3);
    chk("score_29", int'(score), 29);
    for (int k = 0; k < 4; k++) sc(1'b1, S9);
    wait_cyc(3);
    chk("score_99", int'(score), 99);

    // Asynchronous reset mid-stream with partial streaks and err set.
    sc(1'b0, SBAD);
    for (int k = 0; k < 3; k++) begin
      sc(1'b0, S5);
      sc(1'b1, S2);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_score",  int'(score),  0);
    chk("async_rst_lives",  int'(lives),  0);
    chk("async_rst_err",    int'(err),    0);
    chk("async_rst_update", int'(update), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sc(1'b0, S5);
      sc(1'b1, S2);
    end
    wait_cyc(3);
    chk("post_rst_partial", int'(score), 0);
    push(25, 0);
    sc(1'b0, S5);
    sc(1'b1, S2);
    wait_cyc(3);
    chk("post_rst_score", int'(score), 25);
    chk("post_rst_lives", int'(lives), 0);

    wait_cyc(2);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
